// File: rtl/key_load_pkg.sv
// rtl/key_load_pkg.sv - shared defaults and FSM state type for the key loader
//
// Purpose: default parameter values and the controller state enum, imported by
//          key_stage_reg and key_load_ctrl.
// Ports:   none (package).
package key_load_pkg;

  localparam int KEY_W_DEF    = 42;
  localparam int NBYTES_DEF   = 6;
  localparam int TIMEOUT_DEF  = 255;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ARMED,
    S_ERROR,
    S_LOCKOUT
  } state_t;

endpackage

// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - serial key byte load interface
//
// Purpose: groups the load request and byte handshake of the key loader.
// Signals: start     - begin a new key load
//          key_byte  - serial key data, LSB-first byte order
//          key_valid - key_byte is present
//          key_ready - loader accepts key_byte this cycle when high with key_valid
// Modports: master drives start/key_byte/key_valid, slave drives key_ready.
interface key_load_ctrl_if;

  logic       start;
  logic [7:0] key_byte;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output start,
    output key_byte,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  start,
    input  key_byte,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/key_stage_reg.sv
// rtl/key_stage_reg.sv - byte-indexed key staging register and XOR accumulator
//
// Purpose: collects NBYTES key bytes into a staging register, XOR-accumulates
//          them, and holds the trailing checksum byte separately.
// Ports:   clk, rst_n   - clock, synchronous active-low reset
//          clear        - zero staging, accumulator and checksum (new load)
//          wr_en        - store wr_byte at index wr_idx
//          wr_idx       - byte index; index NBYTES is the checksum byte
//          wr_byte      - byte to store
//          staging      - NBYTES bytes, byte i at bits [8*i +: 8]
//          acc          - XOR of all data bytes written since clear
//          chk          - checksum byte
module key_stage_reg
  import key_load_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int IDX_W  = $clog2(NBYTES_DEF + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [7:0]            wr_byte,
  output logic [8*NBYTES-1:0]   staging,
  output logic [7:0]            acc,
  output logic [7:0]            chk
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      staging <= '0;
      acc     <= '0;
      chk     <= '0;
    end else if (wr_en) begin
      if (wr_idx == IDX_W'(NBYTES)) begin
        chk <= wr_byte;
      end else begin
        // The checksum covers data bytes only, never itself.
        acc <= acc ^ wr_byte;
        for (int i = 0; i < NBYTES; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            staging[8*i +: 8] <= wr_byte;
          end
        end
      end
    end
  end

endmodule

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader with checksum check and lockout
//
// Purpose: loads NBYTES key bytes plus a checksum byte, verifies them, and
//          commits the key to the locked netlist; repeated failures lock out.
// Ports:   clk, rst_n  - clock, synchronous active-low reset
//          kif         - slave side of the start/byte handshake
//          key_out     - committed key
//          key_ok      - committed key valid
//          unlock_en   - same as key_ok
//          busy        - load or check in progress
//          err         - last load failed
//          locked      - permanent lockout until reset
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int NBYTES   = NBYTES_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  key_load_ctrl_if.slave    kif,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_ok,
  output logic              unlock_en,
  output logic              busy,
  output logic              err,
  output logic              locked
);

  localparam int SW     = 8 * NBYTES;
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  // Ones over the real key bits; staging bits outside it must be zero padding.
  localparam logic [SW-1:0] KEY_MASK = {SW{1'b1}} >> (SW - KEY_W);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_nxt;
  logic [SW-1:0]     staging;
  logic [7:0]        acc;
  logic [7:0]        chk;
  logic              accept;
  logic              stage_clr;
  logic              last_byte;
  logic              pass_ok;
  logic              tmo_hit;
  logic              fail_ev;

  assign accept    = (state == S_LOAD) && kif.key_valid && kif.key_ready;
  assign stage_clr = kif.start &&
                     ((state == S_IDLE) || (state == S_ARMED) || (state == S_ERROR));
  assign last_byte = (cnt == IDX_W'(NBYTES));
  assign pass_ok   = (acc == chk) && ~|(staging & ~KEY_MASK);
  assign tmo_hit   = (state == S_LOAD) && !accept && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign fail_ev   = ((state == S_CHECK) && !pass_ok) || tmo_hit;
  assign fail_nxt  = fail_cnt + FAIL_W'(1);
  assign unlock_en = key_ok;

  key_stage_reg #(
    .NBYTES (NBYTES),
    .IDX_W  (IDX_W)
  ) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (stage_clr),
    .wr_en   (accept),
    .wr_idx  (cnt),
    .wr_byte (kif.key_byte),
    .staging (staging),
    .acc     (acc),
    .chk     (chk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tmo_cnt       <= '0;
      fail_cnt      <= '0;
      key_out       <= '0;
      key_ok        <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      locked        <= 1'b0;
      kif.key_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ARMED, S_ERROR: begin
          if (kif.start) begin
            state         <= S_LOAD;
            cnt           <= '0;
            tmo_cnt       <= '0;
            err           <= 1'b0;
            key_ok        <= 1'b0;
            busy          <= 1'b1;
            kif.key_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (accept) begin
            tmo_cnt <= '0;
            if (last_byte) begin
              state         <= S_CHECK;
              kif.key_ready <= 1'b0;
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_CHECK: begin
          if (pass_ok) begin
            state    <= S_ARMED;
            key_out  <= staging[KEY_W-1:0];
            key_ok   <= 1'b1;
            fail_cnt <= '0;
            busy     <= 1'b0;
          end
        end
        S_LOCKOUT: begin
        end
        default: state <= S_IDLE;
      endcase

      // Checksum failure and timeout share one failure path.
      if (fail_ev) begin
        busy          <= 1'b0;
        kif.key_ready <= 1'b0;
        err           <= 1'b1;
        fail_cnt      <= fail_nxt;
        if (fail_nxt >= FAIL_W'(MAX_FAIL)) begin
          state   <= S_LOCKOUT;
          locked  <= 1'b1;
          key_out <= '0;
          key_ok  <= 1'b0;
        end else begin
          state <= S_ERROR;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - self-checking bench for key_load_ctrl
module tb_key_load_ctrl;

  typedef struct {
    logic [55:0] bytes;
    logic        exp_ok;
    logic        exp_err;
    logic [41:0] exp_key;
  } vec_t;

  typedef struct {
    logic        ok;
    logic        err;
    logic        lk;
    logic [41:0] key;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [41:0] key_out;
  logic        key_ok, unlock_en, busy, err, locked;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t exp_q[$];
  vec_t vecs[6];

  key_load_ctrl_if kif ();

  key_load_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kif       (kif),
    .key_out   (key_out),
    .key_ok    (key_ok),
    .unlock_en (unlock_en),
    .busy      (busy),
    .err       (err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_key_out"},   64'(key_out), 64'h0);
    check({tag, "_key_ok"},    64'(key_ok), 64'h0);
    check({tag, "_unlock_en"}, 64'(unlock_en), 64'h0);
    check({tag, "_busy"},      64'(busy), 64'h0);
    check({tag, "_err"},       64'(err), 64'h0);
    check({tag, "_locked"},    64'(locked), 64'h0);
    check({tag, "_key_ready"}, 64'(kif.key_ready), 64'h0);
  endtask

  task automatic push_exp(input logic ok, input logic e, input logic lk, input logic [41:0] key);
    exp_t x;
    x.ok = ok; x.err = e; x.lk = lk; x.key = key;
    exp_q.push_back(x);
  endtask

  // Drives one complete load: start pulse, 6 data bytes, checksum byte.
  // With early set, key_valid is also high during the start cycle.
  task automatic send_load(input logic [55:0] b, input bit early);
    kif.start     = 1'b1;
    kif.key_valid = early;
    kif.key_byte  = 8'hAA;
    tick;
    kif.start = 1'b0;
    check("load_ready", 64'(kif.key_ready), 64'h1);
    for (int i = 0; i < 7; i++) begin
      kif.key_valid = 1'b1;
      kif.key_byte  = b[8*i +: 8];
      tick;
    end
    kif.key_valid = 1'b0;
    check("check_cycle_busy",  64'(busy), 64'h1);
    check("check_cycle_ready", 64'(kif.key_ready), 64'h0);
    check("check_cycle_ok",    64'(key_ok), 64'h0);
    tick;
  endtask

  task automatic sb_compare(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'h1, 64'h0);
    end else begin
      x = exp_q.pop_front();
      check({tag, "_key_ok"},    64'(key_ok), 64'(x.ok));
      check({tag, "_unlock_en"}, 64'(unlock_en), 64'(x.ok));
      check({tag, "_err"},       64'(err), 64'(x.err));
      check({tag, "_locked"},    64'(locked), 64'(x.lk));
      check({tag, "_key_out"},   64'(key_out), 64'(x.key));
      check({tag, "_busy"},      64'(busy), 64'h0);
    end
  endtask

  task automatic run_load(input string tag, input logic [55:0] b, input bit early,
                          input logic ok, input logic e, input logic lk, input logic [41:0] key);
    push_exp(ok, e, lk, key);
    send_load(b, early);
    sb_compare(tag);
  endtask

  initial begin
    // bytes are {checksum, byte5 .. byte0}
    vecs[0] = '{56'h8A_0389_6745_2301, 1'b1, 1'b0, 42'h389_6745_2301};
    vecs[1] = '{56'h8B_0389_6745_2301, 1'b0, 1'b1, 42'h389_6745_2301};
    vecs[2] = '{56'hFC_03FF_FFFF_FFFF, 1'b1, 1'b0, 42'h3FF_FFFF_FFFF};
    vecs[3] = '{56'hCA_4389_6745_2301, 1'b0, 1'b1, 42'h3FF_FFFF_FFFF};
    vecs[4] = '{56'h00_0000_0000_0000, 1'b1, 1'b0, 42'h000_0000_0000};
    vecs[5] = '{56'h8A_0389_6745_2301, 1'b1, 1'b0, 42'h389_6745_2301};

    kif.start     = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_byte  = 8'h00;
    rst_n         = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // Table-driven loads; passes interleave so the fail counter never reaches lockout.
    for (int i = 0; i < 6; i++) begin
      run_load($sformatf("vec%0d", i), vecs[i].bytes, 1'b0,
               vecs[i].exp_ok, vecs[i].exp_err, 1'b0, vecs[i].exp_key);
    end

    // start and key_valid together: 0xAA must not be taken as byte 0.
    run_load("early_valid", 56'hFC_03FF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 42'h3FF_FFFF_FFFF);

    // Timeout after two bytes; a start pulse mid-load is ignored.
    kif.start = 1'b1;
    tick;
    kif.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      kif.key_valid = 1'b1;
      kif.key_byte  = 8'h11 * 8'(i + 1);
      tick;
    end
    kif.key_valid = 1'b0;
    for (int i = 0; i < 254; i++) begin
      kif.start = (i == 100);
      tick;
    end
    kif.start = 1'b0;
    check("tmo_pre_busy", 64'(busy), 64'h1);
    check("tmo_pre_err",  64'(err), 64'h0);
    tick;
    check("tmo_err",       64'(err), 64'h1);
    check("tmo_busy",      64'(busy), 64'h0);
    check("tmo_ready",     64'(kif.key_ready), 64'h0);
    check("tmo_key_ok",    64'(key_ok), 64'h0);
    check("tmo_key_kept",  64'(key_out), 64'h3FF_FFFF_FFFF);

    // Fail counter now 1; one more bad load makes it 2.
    run_load("pre_rst_bad", vecs[1].bytes, 1'b0, 1'b0, 1'b1, 1'b0, 42'h3FF_FFFF_FFFF);

    // Reset after the fourth byte of a load.
    kif.start = 1'b1;
    tick;
    kif.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kif.key_valid = 1'b1;
      kif.key_byte  = vecs[0].bytes[8*i +: 8];
      tick;
    end
    kif.key_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_idle_outputs("midload_rst");
    // Fail counter must be back to 0: a single bad load only errors.
    run_load("post_rst_bad", vecs[1].bytes, 1'b0, 1'b0, 1'b1, 1'b0, 42'h0);
    run_load("post_rst_good", vecs[0].bytes, 1'b0, 1'b1, 1'b0, 1'b0, 42'h389_6745_2301);

    // Three consecutive bad loads -> lockout.
    run_load("lk_bad1", vecs[3].bytes, 1'b0, 1'b0, 1'b1, 1'b0, 42'h389_6745_2301);
    run_load("lk_bad2", vecs[1].bytes, 1'b0, 1'b0, 1'b1, 1'b0, 42'h389_6745_2301);
    run_load("lk_bad3", vecs[1].bytes, 1'b0, 1'b0, 1'b1, 1'b1, 42'h0);

    kif.start     = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_byte  = 8'h5A;
    tick;
    kif.start = 1'b0;
    tick;
    tick;
    kif.key_valid = 1'b0;
    check("lk_hold_locked", 64'(locked), 64'h1);
    check("lk_hold_err",    64'(err), 64'h1);
    check("lk_hold_busy",   64'(busy), 64'h0);
    check("lk_hold_ready",  64'(kif.key_ready), 64'h0);
    check("lk_hold_key",    64'(key_out), 64'h0);

    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check_idle_outputs("lk_rst");
    run_load("after_lk_good", vecs[0].bytes, 1'b0, 1'b1, 1'b0, 1'b0, 42'h389_6745_2301);

    check("sb_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
